// File: rtl/bslu_seq_if.sv
// Command and micro-op bus of the BSLU sequencer.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both high; a source holding valid keeps its payload stable until that edge.
interface bslu_seq_if #(
  parameter int ROW_W   = 16,
  parameter int WIDTH_W = 5,
  parameter int IMM_W   = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_code;
  logic [WIDTH_W-1:0] cmd_width;
  logic [ROW_W-1:0]   cmd_src_a;
  logic [ROW_W-1:0]   cmd_src_b;
  logic [ROW_W-1:0]   cmd_cond;
  logic [ROW_W-1:0]   cmd_dst;
  logic [IMM_W-1:0]   cmd_imm;
  logic               uop_valid;
  logic               uop_ready;
  logic [1:0]         uop_type;
  logic [ROW_W-1:0]   uop_row;
  logic [5:0]         uop_op;
  logic [2:0]         uop_rs1;
  logic [2:0]         uop_rs2;
  logic [2:0]         uop_rd;
  logic               busy;
  logic               cmd_done;

  modport master (
    output cmd_valid, cmd_code, cmd_width, cmd_src_a, cmd_src_b, cmd_cond, cmd_dst, cmd_imm,
    output uop_ready,
    input  cmd_ready, uop_valid, uop_type, uop_row, uop_op, uop_rs1, uop_rs2, uop_rd,
    input  busy, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_width, cmd_src_a, cmd_src_b, cmd_cond, cmd_dst, cmd_imm,
    input  uop_ready,
    output cmd_ready, uop_valid, uop_type, uop_row, uop_op, uop_rs1, uop_rs2, uop_rd,
    output busy, cmd_done
  );
endinterface

// File: rtl/bslu_seq.sv
// Expands one bit-serial command (COPY/SETC/EQ/SEL) into a stream of BSLU
// micro-ops: row reads, row writes and logic ops, one per accepted beat.
module bslu_seq #(
  parameter int ROW_W   = 16,
  parameter int WIDTH_W = 5,
  parameter int IMM_W   = 32
) (
  input  logic       clk,
  input  logic       rst,
  bslu_seq_if.slave  bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_BIT   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] C_COPY  = 2'd0;
  localparam logic [1:0] C_SETC  = 2'd1;
  localparam logic [1:0] C_EQ    = 2'd2;
  localparam logic [1:0] C_SEL   = 2'd3;
  localparam logic [1:0] T_READ  = 2'd1;
  localparam logic [1:0] T_WRITE = 2'd2;
  localparam logic [2:0] R_SA    = 3'b001;
  localparam logic [2:0] R_CR    = 3'b010;
  localparam logic [2:0] R_PR    = 3'b100;

  typedef struct packed {
    logic [1:0]       typ;
    logic [ROW_W-1:0] row;
    logic [5:0]       op;
    logic [2:0]       rs1;
    logic [2:0]       rs2;
    logic [2:0]       rd;
  } uop_t;

  // Number of micro-ops in one pass of a phase; 0 means the phase is skipped.
  function automatic logic [2:0] phase_len(input logic [1:0] code, input state_t st);
    logic [2:0] n;
    n = 3'd0;
    case (st)
      S_INIT:  n = (code == C_EQ) ? 3'd1 : ((code == C_SEL) ? 3'd2 : 3'd0);
      S_BIT:   n = (code == C_EQ || code == C_SEL) ? 3'd5 : 3'd2;
      S_FINAL: n = (code == C_EQ) ? 3'd2 : 3'd0;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic uop_t gen_uop(
    input logic [1:0]         code,
    input state_t             st,
    input logic [2:0]         step,
    input logic [WIDTH_W-1:0] bt,
    input logic [ROW_W-1:0]   a,
    input logic [ROW_W-1:0]   b,
    input logic [ROW_W-1:0]   cond,
    input logic [ROW_W-1:0]   dst,
    input logic [IMM_W-1:0]   imm
  );
    uop_t             u;
    logic [ROW_W-1:0] ra;
    logic [ROW_W-1:0] rb;
    logic [ROW_W-1:0] rw;
    u  = '0;
    ra = a + ROW_W'(bt);
    rb = b + ROW_W'(bt);
    rw = dst + ROW_W'(bt);
    case (st)
      S_INIT: begin
        if (code == C_EQ) begin
          u.op = 6'b000110;
          u.rd = R_PR;
        end else if (step == 3'd0) begin
          u.typ = T_READ;
          u.row = cond;
        end else begin
          u.op  = 6'b000001;
          u.rs1 = R_SA;
          u.rd  = R_PR;
        end
      end
      S_BIT: begin
        if (code == C_COPY || code == C_SETC) begin
          if (step != 3'd0) begin
            u.typ = T_WRITE;
            u.row = rw;
          end else if (code == C_COPY) begin
            u.typ = T_READ;
            u.row = ra;
          end else begin
            u.op = {3'b000, imm[bt], 2'b10};
            u.rd = R_SA;
          end
        end else begin
          case (step)
            3'd0: begin
              u.typ = T_READ;
              u.row = ra;
            end
            3'd1: begin
              u.op  = 6'b000001;
              u.rs1 = R_SA;
              u.rd  = R_CR;
            end
            3'd2: begin
              u.typ = T_READ;
              u.row = rb;
            end
            3'd3: begin
              u.op  = (code == C_EQ) ? 6'b010000 : 6'b100000;
              u.rs1 = (code == C_EQ) ? R_SA : R_CR;
              u.rs2 = (code == C_EQ) ? R_CR : R_SA;
              u.rd  = R_SA;
            end
            default: begin
              if (code == C_EQ) begin
                u.op  = 6'b001000;
                u.rs1 = R_PR;
                u.rs2 = R_SA;
                u.rd  = R_PR;
              end else begin
                u.typ = T_WRITE;
                u.row = rw;
              end
            end
          endcase
        end
      end
      S_FINAL: begin
        if (step == 3'd0) begin
          u.op  = 6'b000001;
          u.rs1 = R_PR;
          u.rd  = R_SA;
        end else begin
          u.typ = T_WRITE;
          u.row = dst;
        end
      end
      default: u = '0;
    endcase
    return u;
  endfunction

  state_t             st_q, st_d, nst;
  logic [2:0]         step_q, step_d, nstep;
  logic [WIDTH_W-1:0] bit_q, bit_d, nbit;
  logic [WIDTH_W:0]   bit_inc;
  logic               adv;
  logic [1:0]         code_q, code_d, eff_code;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [ROW_W-1:0]   a_q, a_d, eff_a;
  logic [ROW_W-1:0]   b_q, b_d, eff_b;
  logic [ROW_W-1:0]   cond_q, cond_d, eff_cond;
  logic [ROW_W-1:0]   dst_q, dst_d, eff_dst;
  logic [IMM_W-1:0]   imm_q, imm_d, eff_imm;
  uop_t               uop_q, uop_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    st_d    = st_q;
    step_d  = step_q;
    bit_d   = bit_q;
    code_d  = code_q;
    width_d = width_q;
    a_d     = a_q;
    b_d     = b_q;
    cond_d  = cond_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    uop_d   = uop_q;
    valid_d = valid_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nst     = st_q;
    nstep   = 3'd0;
    nbit    = '0;
    adv     = 1'b0;
    bit_inc = {1'b0, bit_q} + {{WIDTH_W{1'b0}}, 1'b1};

    // On the accept cycle the first micro-op is built from the live command fields.
    eff_code = (st_q == S_IDLE) ? bus.cmd_code  : code_q;
    eff_a    = (st_q == S_IDLE) ? bus.cmd_src_a : a_q;
    eff_b    = (st_q == S_IDLE) ? bus.cmd_src_b : b_q;
    eff_cond = (st_q == S_IDLE) ? bus.cmd_cond  : cond_q;
    eff_dst  = (st_q == S_IDLE) ? bus.cmd_dst   : dst_q;
    eff_imm  = (st_q == S_IDLE) ? bus.cmd_imm   : imm_q;

    case (st_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          code_d  = bus.cmd_code;
          width_d = bus.cmd_width;
          a_d     = bus.cmd_src_a;
          b_d     = bus.cmd_src_b;
          cond_d  = bus.cmd_cond;
          dst_d   = bus.cmd_dst;
          imm_d   = bus.cmd_imm;
          ready_d = 1'b0;
          adv     = 1'b1;
          if (bus.cmd_width == '0) begin
            nst = S_DONE;
          end else if (phase_len(bus.cmd_code, S_INIT) != 3'd0) begin
            nst = S_INIT;
          end else begin
            nst = S_BIT;
          end
        end
      end
      S_INIT, S_BIT, S_FINAL: begin
        if (valid_q && bus.uop_ready) begin
          adv = 1'b1;
          if ((step_q + 3'd1) < phase_len(code_q, st_q)) begin
            nstep = step_q + 3'd1;
            nbit  = bit_q;
          end else if (st_q == S_INIT) begin
            nst = S_BIT;
          end else if (st_q == S_BIT && bit_inc < {1'b0, width_q}) begin
            nbit = bit_inc[WIDTH_W-1:0];
          end else if (st_q == S_BIT && phase_len(code_q, S_FINAL) != 3'd0) begin
            nst = S_FINAL;
          end else begin
            nst = S_DONE;
          end
        end
      end
      S_DONE: begin
        st_d    = S_IDLE;
        ready_d = 1'b1;
      end
      default: st_d = S_IDLE;
    endcase

    if (adv) begin
      st_d   = nst;
      step_d = nstep;
      bit_d  = nbit;
      if (nst == S_DONE) begin
        uop_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        uop_d   = gen_uop(eff_code, nst, nstep, nbit, eff_a, eff_b, eff_cond, eff_dst, eff_imm);
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      step_q  <= '0;
      bit_q   <= '0;
      code_q  <= '0;
      width_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cond_q  <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      uop_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      step_q  <= step_d;
      bit_q   <= bit_d;
      code_q  <= code_d;
      width_q <= width_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cond_q  <= cond_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      uop_q   <= uop_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.uop_valid = valid_q;
  assign bus.uop_type  = uop_q.typ;
  assign bus.uop_row   = uop_q.row;
  assign bus.uop_op    = uop_q.op;
  assign bus.uop_rs1   = uop_q.rs1;
  assign bus.uop_rs2   = uop_q.rs2;
  assign bus.uop_rd    = uop_q.rd;
  assign bus.busy      = busy_q;
  assign bus.cmd_done  = done_q;
  assign dbg_state     = st_q;

endmodule
